// File: rtl/snn_with_delays_top.sv
// -----------------------------------------------------------------------------
// snn_with_delays_top
//
// Two-layer spiking network for the keyword-spotting datapath:
// 24 inputs -> 8 hidden LIF neurons -> 2 output LIF neurons.
// Every synapse has a programmable axonal delay of 0..15 time-steps.
// One time-step is taken on each clock edge where enable is high.
//
// Ports
//   clk                     sole clock, rising edge
//   reset                   asynchronous reset, ACTIVE-LOW despite its name
//   enable                  1 = advance one time-step, 0 = freeze state
//   input_spikes[23:0]      input spike vector, bit i = input i
//   weights[208*Nbits-1:0]  unsigned synapse weights
//                           L1 (hidden j, input i)  at (j*24+i)*Nbits
//                           L2 (output k, hidden j) at (192+k*8+j)*Nbits
//   threshold               shared firing threshold
//   decay                   leak subtracted every step
//   refractory_period       silent steps after a spike
//   delays[208*4-1:0]       per-synapse delay, same indexing, 4-bit fields
//   membrane_potential_out  hidden j at j*Nbits, output k at (8+k)*Nbits
//   output_spikes_layer1    registered hidden spikes
//   output_spikes           registered output spikes
//
// Build option
//   SNN_POTENTIAL_OUT_EN    defined: membrane_potential_out shows the live
//                           potentials; undefined: the port is tied to 0.
// -----------------------------------------------------------------------------
module snn_with_delays_top #(
    parameter int Nbits = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [23:0]          input_spikes,
    input  logic [208*Nbits-1:0] weights,
    input  logic [Nbits-1:0]     threshold,
    input  logic [Nbits-1:0]     decay,
    input  logic [Nbits-1:0]     refractory_period,
    input  logic [208*4-1:0]     delays,
    output logic [10*Nbits-1:0]  membrane_potential_out,
    output logic [7:0]           output_spikes_layer1,
    output logic [1:0]           output_spikes
);

    // Current accumulator sized for the wider (layer-1) fan-in; layer 2 fits.
    localparam int CW = Nbits + 5;
    localparam logic [CW:0] VMAX = (CW+1)'((1 << Nbits) - 1);

    // Delay-line histories: r_in_hist[d] is the value d enabled steps ago.
    logic [23:0]      r_in_hist  [1:15];
    logic [7:0]       r_hid_hist [1:15];
    logic [Nbits-1:0] r_v        [0:9];
    logic [Nbits-1:0] r_cnt      [0:9];
    logic [7:0]       r_spk_l1;
    logic [1:0]       r_spk_l2;

    logic [23:0]      w_in_tap   [0:15];
    logic [7:0]       w_hid_tap  [0:15];
    logic [CW-1:0]    w_cur      [0:9];
    logic [Nbits-1:0] w_vn       [0:9];
    logic [Nbits-1:0] w_v_next   [0:9];
    logic [Nbits-1:0] w_cnt_next [0:9];
    logic [9:0]       w_spk_next;

    function automatic logic [Nbits-1:0] leak(input logic [Nbits-1:0] v,
                                              input logic [Nbits-1:0] dcy);
        return (v > dcy) ? v - dcy : '0;
    endfunction

    function automatic logic [Nbits-1:0] sat_add(input logic [Nbits-1:0] v,
                                                 input logic [CW-1:0]    c);
        logic [CW:0] s;
        s = (CW+1)'(v) + (CW+1)'(c);
        if (s > VMAX) return '1;
        return s[Nbits-1:0];
    endfunction

    // Tap 0 is the live source; layer 2 sources from the hidden spike register.
    always_comb begin
        w_in_tap[0]  = input_spikes;
        w_hid_tap[0] = r_spk_l1;
        for (int k = 1; k < 16; k++) begin
            w_in_tap[k]  = r_in_hist[k];
            w_hid_tap[k] = r_hid_hist[k];
        end
    end

    // Synaptic current: sum of weights whose delayed spike is set.
    always_comb begin
        for (int n = 0; n < 10; n++) w_cur[n] = '0;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 24; i++) begin
                if (w_in_tap[delays[(j*24+i)*4 +: 4]][i])
                    w_cur[j] = w_cur[j] + CW'(weights[(j*24+i)*Nbits +: Nbits]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (w_hid_tap[delays[(192+k*8+j)*4 +: 4]][j])
                    w_cur[8+k] = w_cur[8+k] + CW'(weights[(192+k*8+j)*Nbits +: Nbits]);
            end
        end
    end

    // LIF update. A zero current never fires, even with threshold 0.
    always_comb begin
        w_spk_next = '0;
        for (int n = 0; n < 10; n++) begin
            w_vn[n]       = sat_add(leak(r_v[n], decay), w_cur[n]);
            w_v_next[n]   = w_vn[n];
            w_cnt_next[n] = r_cnt[n];
            if (r_cnt[n] != '0) begin
                w_cnt_next[n] = r_cnt[n] - Nbits'(1);
                w_v_next[n]   = '0;
            end else if ((w_vn[n] >= threshold) && (w_cur[n] != '0)) begin
                w_spk_next[n] = 1'b1;
                w_v_next[n]   = '0;
                w_cnt_next[n] = refractory_period;
            end
        end
    end

    // Stage boundary: all network state; disabled edges hold state and clear spikes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k < 16; k++) begin
                r_in_hist[k]  <= '0;
                r_hid_hist[k] <= '0;
            end
            for (int n = 0; n < 10; n++) begin
                r_v[n]   <= '0;
                r_cnt[n] <= '0;
            end
            r_spk_l1 <= '0;
            r_spk_l2 <= '0;
        end else if (enable) begin
            r_in_hist[1]  <= input_spikes;
            r_hid_hist[1] <= r_spk_l1;
            for (int k = 2; k < 16; k++) begin
                r_in_hist[k]  <= r_in_hist[k-1];
                r_hid_hist[k] <= r_hid_hist[k-1];
            end
            for (int n = 0; n < 10; n++) begin
                r_v[n]   <= w_v_next[n];
                r_cnt[n] <= w_cnt_next[n];
            end
            r_spk_l1 <= w_spk_next[7:0];
            r_spk_l2 <= w_spk_next[9:8];
        end else begin
            r_spk_l1 <= '0;
            r_spk_l2 <= '0;
        end
    end

    assign output_spikes_layer1 = r_spk_l1;
    assign output_spikes        = r_spk_l2;

`ifdef SNN_POTENTIAL_OUT_EN
    always_comb begin
        membrane_potential_out = '0;
        for (int n = 0; n < 10; n++)
            membrane_potential_out[n*Nbits +: Nbits] = r_v[n];
    end
`else
    assign membrane_potential_out = '0;
`endif

endmodule

// File: tb/tb_snn_with_delays_top.sv
module tb_snn_with_delays_top;

    localparam int NB   = 4;
    localparam int VMAX = (1 << NB) - 1;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [23:0]     input_spikes;
    logic [208*NB-1:0] weights;
    logic [NB-1:0]   threshold;
    logic [NB-1:0]   decay;
    logic [NB-1:0]   refractory_period;
    logic [208*4-1:0] delays;
    logic [10*NB-1:0] membrane_potential_out;
    logic [7:0]      output_spikes_layer1;
    logic [1:0]      output_spikes;

    snn_with_delays_top #(.Nbits(NB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .input_spikes           (input_spikes),
        .weights                (weights),
        .threshold              (threshold),
        .decay                  (decay),
        .refractory_period      (refractory_period),
        .delays                 (delays),
        .membrane_potential_out (membrane_potential_out),
        .output_spikes_layer1   (output_spikes_layer1),
        .output_spikes          (output_spikes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit [7:0]       l1;
        bit [1:0]       l2;
        bit [10*NB-1:0] pot;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int        m_w[208];
    int        m_dl[208];
    int        m_thr, m_dec, m_ref;
    bit [23:0] in_past[$];
    bit [7:0]  hid_past[$];
    int        m_v[10];
    int        m_c[10];
    bit [7:0]  m_l1;
    bit [1:0]  m_l2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        in_past.delete();
        hid_past.delete();
        for (int k = 0; k < 15; k++) begin
            in_past.push_back(24'h0);
            hid_past.push_back(8'h0);
        end
        for (int n = 0; n < 10; n++) begin
            m_v[n] = 0;
            m_c[n] = 0;
        end
        m_l1 = '0;
        m_l2 = '0;
    endtask

    task automatic model_step(input bit [23:0] x, input bit en);
        int cur[10];
        int vl, vn, d, idx;
        bit s;
        bit [9:0] fire;
        if (!en) begin
            m_l1 = '0;
            m_l2 = '0;
            return;
        end
        fire = '0;
        for (int n = 0; n < 10; n++) cur[n] = 0;
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 24; i++) begin
                idx = j*24 + i;
                d = m_dl[idx];
                s = (d == 0) ? x[i] : in_past[d-1][i];
                if (s) cur[j] += m_w[idx];
            end
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 8; j++) begin
                idx = 192 + k*8 + j;
                d = m_dl[idx];
                s = (d == 0) ? m_l1[j] : hid_past[d-1][j];
                if (s) cur[8+k] += m_w[idx];
            end
        for (int n = 0; n < 10; n++) begin
            if (m_c[n] > 0) begin
                m_c[n]--;
                m_v[n] = 0;
            end else begin
                vl = m_v[n] - m_dec;
                if (vl < 0) vl = 0;
                vn = vl + cur[n];
                if (vn > VMAX) vn = VMAX;
                if (vn >= m_thr && cur[n] > 0) begin
                    fire[n] = 1'b1;
                    m_v[n]  = 0;
                    m_c[n]  = m_ref;
                end else begin
                    m_v[n] = vn;
                end
            end
        end
        in_past.push_front(x);
        void'(in_past.pop_back());
        hid_past.push_front(m_l1);
        void'(hid_past.pop_back());
        m_l1 = fire[7:0];
        m_l2 = fire[9:8];
    endtask

    function automatic bit [10*NB-1:0] exp_pot();
        bit [10*NB-1:0] p;
        p = '0;
`ifdef SNN_POTENTIAL_OUT_EN
        for (int n = 0; n < 10; n++) p[n*NB +: NB] = NB'(m_v[n]);
`endif
        return p;
    endfunction

    task automatic drive_cfg();
        for (int n = 0; n < 208; n++) begin
            weights[n*NB +: NB] = NB'(m_w[n]);
            delays[n*4 +: 4]    = 4'(m_dl[n]);
        end
        threshold         = NB'(m_thr);
        decay             = NB'(m_dec);
        refractory_period = NB'(m_ref);
    endtask

    task automatic clear_cfg();
        for (int n = 0; n < 208; n++) begin
            m_w[n]  = 0;
            m_dl[n] = 0;
        end
        m_thr = 0;
        m_dec = 0;
        m_ref = 0;
    endtask

    // One time-step: drive at the falling edge, queue the expected result.
    task automatic cycle(input bit [23:0] x, input bit en);
        exp_t e;
        @(negedge clk);
        input_spikes = x;
        enable       = en;
        drive_cfg();
        model_step(x, en);
        e.l1  = m_l1;
        e.l2  = m_l2;
        e.pot = exp_pot();
        sb.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk({tag, "_rst_l1"},  output_spikes_layer1,   '0);
        chk({tag, "_rst_l2"},  output_spikes,          '0);
        chk({tag, "_rst_pot"}, membrane_potential_out, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic random_cfg();
        for (int n = 0; n < 208; n++) begin
            m_w[n]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
            m_dl[n] = $urandom_range(0, 15);
        end
        m_thr = $urandom_range(0, 15);
        m_dec = $urandom_range(0, 3);
        m_ref = $urandom_range(0, 3);
    endtask

    // Monitor: compare every clocked output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("l1_spikes",  output_spikes_layer1,   e.l1);
                chk("l2_spikes",  output_spikes,          e.l2);
                chk("potentials", membrane_potential_out, e.pot);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        input_spikes = '0;
        clear_cfg();
        drive_cfg();
        model_reset();
        #1;
        chk("init_l1",  output_spikes_layer1,   '0);
        chk("init_l2",  output_spikes,          '0);
        chk("init_pot", membrane_potential_out, '0);

        // Saturating burst
        do_reset("burst");
        for (int n = 0; n < 208; n++) m_w[n] = 7;
        m_thr = 1; m_dec = 2; m_ref = 0;
        for (int c = 0; c < 3; c++) cycle(24'hABCDEF, 1'b1);
        @(posedge clk); #2;
        chk("burst_l1_ff", output_spikes_layer1, 8'hFF);
        chk("burst_l2_11", output_spikes,        2'b11);
        for (int c = 0; c < 5; c++) cycle(24'hABCDEF, 1'b1);

        // Refractory 3
        do_reset("refr");
        m_ref = 3;
        for (int c = 0; c < 12; c++) cycle(24'hABCDEF, 1'b1);

        // Single delayed synapse
        do_reset("delay");
        clear_cfg();
        m_w[0] = 5; m_dl[0] = 5; m_thr = 5;
        cycle(24'h000001, 1'b1);
        for (int c = 0; c < 10; c++) cycle(24'h0, 1'b1);

        // Leak and accumulation, then enable gating mid-charge
        do_reset("leak");
        clear_cfg();
        m_w[0] = 3; m_thr = 8; m_dec = 1;
        for (int c = 0; c < 6; c++) cycle(24'h000001, 1'b1);
        for (int c = 0; c < 2; c++) cycle(24'h000001, 1'b1);
        for (int c = 0; c < 10; c++) cycle(24'h000001, 1'b0);
        for (int c = 0; c < 6; c++) cycle(24'h000001, 1'b1);

        // Randomized operation with config changes and enable gaps
        do_reset("rand");
        for (int blk = 0; blk < 6; blk++) begin
            random_cfg();
            for (int c = 0; c < 60; c++)
                cycle($urandom & $urandom, ($urandom_range(0, 9) != 0));
        end

        // Mid-run async reset with charged neurons, then hold with enable low
        do_reset("midrun");
        for (int c = 0; c < 4; c++) cycle($urandom, 1'b0);
        random_cfg();
        for (int c = 0; c < 30; c++) cycle($urandom & $urandom, 1'b1);

        @(posedge clk); #3;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
